// File: rtl/hdmi_timing_compositor.sv
// ============================================================================
// hdmi_timing_compositor
//
// Raster timing generator plus two-layer pixel compositor for an HDMI
// transmitter. A background pixel is fetched from a frame buffer. A
// rectangular overlay with colour-key transparency is fetched from a second
// memory and placed over it. Every output is aligned to the transmitter, so
// DE, HSYNC, VSYNC, HDMI_PX and FRAME_START all change on the same edge.
//
// Pipeline (one column per clock edge):
//   counter stage (h, v) -> address registers -> MEM_LAT memory cycles
//   -> registered colour select / sync / DE outputs
//   Total latency from counter to outputs: MEM_LAT + 2 cycles.
//
// Optional feature: define HDMI_TEST_PATTERN_EN to add the TPG input. When
// TPG is latched high at frame start, the background is replaced by eight
// vertical colour bars. The overlay and INV still apply, and PX_ADDR still
// advances.
//
// Ports:
//   CLK_PX       in   pixel clock
//   RST          in   synchronous active-high reset
//   INV          in   invert background pixels (overlay unaffected)
//   OVL_EN       in   overlay enable, sampled at frame start
//   OVL_X/OVL_Y  in   overlay top-left position, sampled at frame start
//   KEY          in   overlay transparent colour, sampled at frame start
//   TPG          in   test pattern select (HDMI_TEST_PATTERN_EN only)
//   PX           in   background pixel, valid MEM_LAT cycles after PX_ADDR
//   OVL_PX       in   overlay pixel, valid MEM_LAT cycles after OVL_ADDR
//   PX_ADDR      out  background read address
//   OVL_ADDR     out  overlay read address
//   HDMI_CLK     out  forwarded pixel clock
//   DE           out  data enable
//   HSYNC/VSYNC  out  syncs, active level given by SYNC_POL
//   HDMI_PX      out  composited pixel {R,G,B}
//   FRAME_START  out  pulse aligned with the first active DE of a frame
// ============================================================================
module hdmi_timing_compositor #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned OVL_W    = 100,
    parameter int unsigned OVL_H    = 40,
    parameter int unsigned PX_AW    = 19,
    parameter int unsigned OVL_AW   = 14
) (
    input  logic              CLK_PX,
    input  logic              RST,
    input  logic              INV,
    input  logic              OVL_EN,
    input  logic [9:0]        OVL_X,
    input  logic [9:0]        OVL_Y,
    input  logic [23:0]       KEY,
`ifdef HDMI_TEST_PATTERN_EN
    input  logic              TPG,
`endif
    input  logic [23:0]       PX,
    input  logic [23:0]       OVL_PX,
    output logic [PX_AW-1:0]  PX_ADDR,
    output logic [OVL_AW-1:0] OVL_ADDR,
    output logic              HDMI_CLK,
    output logic              DE,
    output logic              HSYNC,
    output logic              VSYNC,
    output logic [23:0]       HDMI_PX,
    output logic              FRAME_START
);

    // ------------------------------------------------------------------
    // Derived raster constants
    // ------------------------------------------------------------------
    localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW           = $clog2(H_TOTAL);
    localparam int unsigned VW           = $clog2(V_TOTAL);
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;
`ifdef HDMI_TEST_PATTERN_EN
    localparam int unsigned BAR_W        = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
`endif

    // Per-pixel control flags carried alongside the memory read latency.
    typedef struct packed {
        logic       act;
        logic       in_ovl;
        logic       hs;
        logic       vs;
        logic       fs;
`ifdef HDMI_TEST_PATTERN_EN
        logic       tpg;
        logic [2:0] bar;
`endif
    } stage_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [HW-1:0]          h_q, h_d;
    logic [VW-1:0]          v_q, v_d;

    logic                   sh_en_q, sh_en_d;
    logic [9:0]             sh_x_q, sh_x_d;
    logic [9:0]             sh_y_q, sh_y_d;
    logic [23:0]            sh_key_q, sh_key_d;
`ifdef HDMI_TEST_PATTERN_EN
    logic                   sh_tpg_q, sh_tpg_d;
`endif

    logic [PX_AW-1:0]       px_addr_q, px_addr_d;
    logic [OVL_AW-1:0]      ovl_addr_q, ovl_addr_d;
    logic [OVL_AW-1:0]      ovl_ptr_q, ovl_ptr_d;

    stage_t [MEM_LAT:0]     pipe_q, pipe_d;

    logic                   de_q, de_d;
    logic                   hsync_q, hsync_d;
    logic                   vsync_q, vsync_d;
    logic [23:0]            hdmi_px_q, hdmi_px_d;
    logic                   frame_start_q, frame_start_d;

    // Counter-stage decode
    logic [31:0]            h_w, v_w, dx, dy;
    logic                   act, hs_raw, vs_raw, frame_start, in_ovl;
    logic [OVL_AW-1:0]      ovl_cur;
    stage_t                 head;
    stage_t                 al;
    logic [23:0]            bg;
`ifdef HDMI_TEST_PATTERN_EN
    logic [31:0]            bar_idx;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF; // white
            3'd1:    c = 24'hFFFF00; // yellow
            3'd2:    c = 24'h00FFFF; // cyan
            3'd3:    c = 24'h00FF00; // green
            3'd4:    c = 24'hFF00FF; // magenta
            3'd5:    c = 24'hFF0000; // red
            3'd6:    c = 24'h0000FF; // blue
            default: c = 24'h000000; // black
        endcase
        return c;
    endfunction
`endif

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        h_d = h_q;
        v_d = v_q;
        if (h_q == HW'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
        end else begin
            h_d = h_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Counter stage: region decode, shadow registers, overlay window and
    // address generation
    // ------------------------------------------------------------------
    always_comb begin
        h_w         = 32'(h_q);
        v_w         = 32'(v_q);
        act         = (h_w < H_ACTIVE) && (v_w < V_ACTIVE);
        hs_raw      = (h_w >= H_SYNC_START) && (h_w < H_SYNC_END);
        vs_raw      = (v_w >= V_SYNC_START) && (v_w < V_SYNC_END);
        frame_start = (h_q == '0) && (v_q == '0);

        // The shadow copy used for this pixel already includes the values
        // latched on the frame-start pixel, so the first pixel of a frame
        // sees the new overlay settings.
        sh_en_d  = frame_start ? OVL_EN : sh_en_q;
        sh_x_d   = frame_start ? OVL_X  : sh_x_q;
        sh_y_d   = frame_start ? OVL_Y  : sh_y_q;
        sh_key_d = frame_start ? KEY    : sh_key_q;
`ifdef HDMI_TEST_PATTERN_EN
        sh_tpg_d = frame_start ? TPG    : sh_tpg_q;
`endif

        // Unsigned differences wrap huge when h/v is left of/above the
        // window, so the range check also needs the lower-bound compare.
        dx     = h_w - 32'(sh_x_d);
        dy     = v_w - 32'(sh_y_d);
        in_ovl = sh_en_d && act
                 && (h_w >= 32'(sh_x_d)) && (dx < OVL_W)
                 && (v_w >= 32'(sh_y_d)) && (dy < OVL_H);

        // Background address: one step per active pixel, restarting at 0
        // on the first pixel of each frame.
        px_addr_d = px_addr_q;
        if (act) begin
            px_addr_d = frame_start ? '0 : px_addr_q + 1'b1;
        end

        // Overlay address: ovl_ptr tracks the address of the next visible
        // overlay pixel. On the last visible column of a row it jumps to the
        // start of the next overlay row. When the window is clipped on the
        // right, the last visible column is H_ACTIVE-1 and the jump skips the
        // hidden columns. Without clipping the jump equals +1, so a single
        // rule covers both cases.
        ovl_cur    = frame_start ? '0 : ovl_ptr_q;
        ovl_ptr_d  = ovl_cur;
        ovl_addr_d = ovl_addr_q;
        if (in_ovl) begin
            ovl_addr_d = ovl_cur;
            if (h_w == H_ACTIVE - 1) begin
                ovl_ptr_d = ovl_cur + OVL_AW'(OVL_W - dx);
            end else begin
                ovl_ptr_d = ovl_cur + 1'b1;
            end
        end

        head        = '0;
        head.act    = act;
        head.in_ovl = in_ovl;
        head.hs     = hs_raw;
        head.vs     = vs_raw;
        head.fs     = frame_start;
`ifdef HDMI_TEST_PATTERN_EN
        bar_idx     = h_w / BAR_W;
        head.tpg    = sh_tpg_d;
        head.bar    = (bar_idx > 32'd7) ? 3'd7 : bar_idx[2:0];
`endif
    end

    // Shift the flags by MEM_LAT+1: one cycle for the address register plus
    // the memory read latency, so pipe_q[MEM_LAT] lines up with PX/OVL_PX.
    always_comb begin
        pipe_d = {pipe_q[MEM_LAT-1:0], head};
    end

    // ------------------------------------------------------------------
    // Aligned stage: colour select and output drive
    // ------------------------------------------------------------------
    always_comb begin
        al = pipe_q[MEM_LAT];

        bg = PX;
`ifdef HDMI_TEST_PATTERN_EN
        if (al.tpg) begin
            bg = bar_colour(al.bar);
        end
`endif
        // INV is used live at this stage and is not shadowed.
        if (INV) begin
            bg = ~bg;
        end

        hdmi_px_d = 24'h000000;
        if (al.act) begin
            // The key register is stable here: it only changes on a frame
            // start, and the pixels still in flight at that moment are
            // blanking pixels.
            if (al.in_ovl && (OVL_PX != sh_key_q)) begin
                hdmi_px_d = OVL_PX;
            end else begin
                hdmi_px_d = bg;
            end
        end

        de_d          = al.act;
        hsync_d       = SYNC_POL ? al.hs : ~al.hs;
        vsync_d       = SYNC_POL ? al.vs : ~al.vs;
        frame_start_d = al.fs;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_PX) begin
        // NOTE: reset is synchronous; it is checked only inside the clocked
        // block, so RST never appears in the sensitivity list.
        if (RST) begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // register samples the pre-edge values of the others.
            h_q           <= '0;
            v_q           <= '0;
            sh_en_q       <= 1'b0;
            sh_x_q        <= '0;
            sh_y_q        <= '0;
            sh_key_q      <= '0;
`ifdef HDMI_TEST_PATTERN_EN
            sh_tpg_q      <= 1'b0;
`endif
            px_addr_q     <= '0;
            ovl_addr_q    <= '0;
            ovl_ptr_q     <= '0;
            pipe_q        <= '0;
            de_q          <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            hdmi_px_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            sh_en_q       <= sh_en_d;
            sh_x_q        <= sh_x_d;
            sh_y_q        <= sh_y_d;
            sh_key_q      <= sh_key_d;
`ifdef HDMI_TEST_PATTERN_EN
            sh_tpg_q      <= sh_tpg_d;
`endif
            px_addr_q     <= px_addr_d;
            ovl_addr_q    <= ovl_addr_d;
            ovl_ptr_q     <= ovl_ptr_d;
            pipe_q        <= pipe_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hdmi_px_q     <= hdmi_px_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign PX_ADDR     = px_addr_q;
    assign OVL_ADDR    = ovl_addr_q;
    assign HDMI_CLK    = CLK_PX;
    assign DE          = de_q;
    assign HSYNC       = hsync_q;
    assign VSYNC       = vsync_q;
    assign HDMI_PX     = hdmi_px_q;
    assign FRAME_START = frame_start_q;

endmodule

// File: tb/tb_hdmi_timing_compositor.sv
// ============================================================================
// tb_hdmi_timing_compositor
//
// Directed bench for hdmi_timing_compositor on a reduced raster
// (16x10 active, 24x15 total, 360 cycles per frame) with MEM_LAT = 3.
// The memory models return the address as the pixel value. The overlay
// memory returns 24'h800000 | address, except that address 5 returns 0,
// which matches KEY = 0. The bench follows the raster from reset, captures
// each frame into a buffer, and compares chosen pixels and per-frame
// counts against hand-computed values.
// ============================================================================
module tb_hdmi_timing_compositor;

    localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
    localparam int VA = 10, VFP = 1, VSW = 2, VBP = 2;
    localparam int HT = HA + HFP + HSW + HBP;  // 24
    localparam int VT = VA + VFP + VSW + VBP;  // 15
    localparam int FRAME = HT * VT;            // 360
    localparam int MEM_LAT = 3;
    localparam int LAT = MEM_LAT + 2;
    localparam int OW = 4, OH = 3;
    localparam int PX_AW = 19, OVL_AW = 14;

    logic              clk = 1'b0;
    logic              rst, inv, ovl_en;
    logic [9:0]        ovl_x, ovl_y;
    logic [23:0]       key, px, ovl_px;
    logic [PX_AW-1:0]  px_addr;
    logic [OVL_AW-1:0] ovl_addr;
    logic              hdmi_clk, de, hsync, vsync, frame_start;
    logic [23:0]       hdmi_px;

    always #5 clk = ~clk;

    hdmi_timing_compositor #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SYNC_POL(1'b0), .MEM_LAT(MEM_LAT), .OVL_W(OW), .OVL_H(OH),
        .PX_AW(PX_AW), .OVL_AW(OVL_AW)
    ) dut (
        .CLK_PX(clk), .RST(rst), .INV(inv), .OVL_EN(ovl_en),
        .OVL_X(ovl_x), .OVL_Y(ovl_y), .KEY(key),
        .PX(px), .OVL_PX(ovl_px),
        .PX_ADDR(px_addr), .OVL_ADDR(ovl_addr), .HDMI_CLK(hdmi_clk),
        .DE(de), .HSYNC(hsync), .VSYNC(vsync), .HDMI_PX(hdmi_px),
        .FRAME_START(frame_start)
    );

    // Memory models with MEM_LAT cycles of read latency
    logic [PX_AW-1:0]  px_pipe  [MEM_LAT];
    logic [OVL_AW-1:0] ovl_pipe [MEM_LAT];
    always @(posedge clk) begin
        px_pipe[0]  <= px_addr;
        ovl_pipe[0] <= ovl_addr;
        for (int i = 1; i < MEM_LAT; i++) begin
            px_pipe[i]  <= px_pipe[i-1];
            ovl_pipe[i] <= ovl_pipe[i-1];
        end
    end
    assign px     = 24'(px_pipe[MEM_LAT-1]);
    assign ovl_px = (ovl_pipe[MEM_LAT-1] == OVL_AW'(5)) ? 24'h000000
                    : (24'h800000 | 24'(ovl_pipe[MEM_LAT-1]));

    // Cycle index since the last reset edge
    int k = 0;
    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Raster monitor: output cycle k carries pixel position k - LAT
    bit          mon_en = 1'b0;
    int          timing_err = 0;
    logic [23:0] pix [2][VA][HA];
    int          cnt_de [2];
    int          cnt_hs [2];
    int          cnt_vs [2];
    int          cnt_fs [2];
    int          cnt_ovl [2];

    always @(negedge clk) begin
        int pos, h, v, s;
        bit e_de, e_hs, e_vs, e_fs;
        if (mon_en) begin
            pos  = k - LAT;
            e_de = 1'b0;
            e_hs = 1'b1;
            e_vs = 1'b1;
            e_fs = 1'b0;
            if (pos >= 0) begin
                h    = pos % HT;
                v    = (pos / HT) % VT;
                s    = (pos / FRAME) % 2;
                e_de = (h < HA) && (v < VA);
                e_hs = !((h >= HA + HFP) && (h < HA + HFP + HSW));
                e_vs = !((v >= VA + VFP) && (v < VA + VFP + VSW));
                e_fs = (h == 0) && (v == 0);
                if (e_fs) begin
                    cnt_de[s] = 0; cnt_hs[s] = 0; cnt_vs[s] = 0;
                    cnt_fs[s] = 0; cnt_ovl[s] = 0;
                end
                if (de)           cnt_de[s]++;
                if (!hsync)       cnt_hs[s]++;
                if (!vsync)       cnt_vs[s]++;
                if (frame_start)  cnt_fs[s]++;
                if (e_de) begin
                    pix[s][v][h] = hdmi_px;
                    if (hdmi_px[23]) cnt_ovl[s]++;
                end
            end
            if (de !== e_de || hsync !== e_hs || vsync !== e_vs ||
                frame_start !== e_fs || (!e_de && hdmi_px !== 24'h0))
                timing_err++;
        end
    end

    task automatic wait_k(input int target);
        int guard;
        guard = 0;
        while (k < target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (k < target) check("wait_timeout", k, target);
    endtask

    initial begin
        rst = 1'b1; inv = 1'b0; ovl_en = 1'b0;
        ovl_x = 10'd3; ovl_y = 10'd2; key = 24'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        // Reset state
        check("rst_de",    de, 0);
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);
        check("rst_px",    hdmi_px, 0);
        check("rst_fs",    frame_start, 0);
        check("rst_paddr", px_addr, 0);
        check("rst_oaddr", ovl_addr, 0);
        mon_en = 1'b1;
        rst    = 1'b0;

        // Frame 1 configuration: overlay at (3,2)
        wait_k(10);
        ovl_en = 1'b1; ovl_x = 10'd3; ovl_y = 10'd2;

        // Frame 0: timing, alignment, overlay disabled
        wait_k(FRAME + 20);
        check("f0_de_cnt",  cnt_de[0], HA * VA);
        check("f0_hs_low",  cnt_hs[0], HSW * VT);
        check("f0_vs_low",  cnt_vs[0], VSW * HT);
        check("f0_fs_cnt",  cnt_fs[0], 1);
        check("f0_first",   pix[0][0][0], 0);
        check("f0_second",  pix[0][0][1], 1);
        check("f0_last",    pix[0][9][15], 159);
        check("f0_mid",     pix[0][5][7], 87);
        check("f0_no_ovl",  cnt_ovl[0], 0);

        // Mid-frame move during frame 1 takes effect in frame 2 only
        wait_k(FRAME + HT + 3);
        ovl_x = 10'd8;

        wait_k(2 * FRAME + 20);
        check("f1_ovl_tl",   pix[1][2][3], 24'h800000);
        check("f1_keyed",    pix[1][3][4], 52);
        check("f1_ovl_br",   pix[1][4][6], 24'h80000B);
        check("f1_right",    pix[1][4][7], 71);
        check("f1_left",     pix[1][2][2], 34);
        check("f1_below",    pix[1][5][3], 83);
        check("f1_shadow",   pix[1][2][8], 40);
        check("f1_ovl_cnt",  cnt_ovl[1], 11);
        check("f1_fs_cnt",   cnt_fs[1], 1);
        // Frame 3 configuration: window clipped at bottom-right
        ovl_x = 10'd14; ovl_y = 10'd8;

        wait_k(3 * FRAME + 20);
        check("f2_ovl_tl",   pix[0][2][8], 24'h800000);
        check("f2_old_pos",  pix[0][2][3], 35);
        check("f2_ovl_br",   pix[0][4][11], 24'h80000B);
        check("f2_right",    pix[0][4][12], 76);
        check("f2_ovl_cnt",  cnt_ovl[0], 11);

        wait_k(4 * FRAME + 20);
        check("f3_clip_00",  pix[1][8][14], 24'h800000);
        check("f3_clip_01",  pix[1][8][15], 24'h800001);
        check("f3_row_skip", pix[1][9][14], 24'h800004);
        check("f3_keyed",    pix[1][9][15], 159);
        check("f3_left",     pix[1][8][13], 141);
        check("f3_next_ln",  pix[1][9][0], 144);
        check("f3_ovl_cnt",  cnt_ovl[1], 3);
        check("timing_pre",  timing_err, 0);

        // Reset in the middle of an active line of frame 4
        wait_k(4 * FRAME + 6 * HT + 8);
        check("pre_rst_de", de, 1);
        rst = 1'b1; inv = 1'b1; ovl_x = 10'd3; ovl_y = 10'd2;
        @(negedge clk);
        check("mid_rst_de",    de, 0);
        check("mid_rst_paddr", px_addr, 0);
        check("mid_rst_oaddr", ovl_addr, 0);
        check("mid_rst_hs",    hsync, 1);
        check("mid_rst_vs",    vsync, 1);
        check("mid_rst_px",    hdmi_px, 0);
        rst = 1'b0;

        // First frame after reset, INV = 1
        wait_k(FRAME + 20);
        check("r_first_inv", pix[0][0][0], 24'hFFFFFF);
        check("r_mid_inv",   pix[0][5][5], 24'hFFFFAA);
        check("r_ovl",       pix[0][2][3], 24'h800000);
        check("r_keyed_inv", pix[0][3][4], 24'hFFFFCB);
        check("r_de_cnt",    cnt_de[0], HA * VA);
        check("r_fs_cnt",    cnt_fs[0], 1);
        check("timing_all",  timing_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hdmi_timing_compositor.md
Name: hdmi_timing_compositor

Overview:
- Parametrised successor of the fixed 640x480 HDMI controller: raster timing generator plus two-layer compositor (background frame buffer + rectangular overlay).
- Generalised resolution, sync polarity, and memory read latency.
- Runtime-positioned overlay with colour-key transparency.
- Sits between the frame/overlay ROMs/RAMs and the HDMI transmitter; all outputs are pipeline-aligned to the transmitter.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, active lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
SYNC_POL, 0, 0 = sync pulses active-low, 1 = active-high (both H and V)
MEM_LAT, 1, read latency in cycles of both pixel memories (1..4)
OVL_W, 100, overlay width in pixels
OVL_H, 40, overlay height in lines
PX_AW, 19, background address width
OVL_AW, 14, overlay address width

Ports:
CLK_PX  in  1  pixel clock
RST  in  1  synchronous active-high reset
INV  in  1  invert background pixels (overlay unaffected)
OVL_EN  in  1  overlay enable, sampled at frame start
OVL_X  in  10  overlay left column, sampled at frame start
OVL_Y  in  10  overlay top line, sampled at frame start
KEY  in  24  transparent colour for overlay, sampled at frame start
PX  in  24  background pixel, valid MEM_LAT cycles after PX_ADDR
OVL_PX  in  24  overlay pixel, valid MEM_LAT cycles after OVL_ADDR
PX_ADDR  out  PX_AW  background read address
OVL_ADDR  out  OVL_AW  overlay read address
HDMI_CLK  out  1  equals CLK_PX
DE  out  1  data enable
HSYNC  out  1  horizontal sync, polarity per SYNC_POL
VSYNC  out  1  vertical sync, polarity per SYNC_POL
HDMI_PX  out  24  composited pixel {R,G,B}
FRAME_START  out  1  one-cycle pulse aligned with the first active DE of each frame

Behaviour:
- Clock and reset: single clock. Reset is synchronous and active-high; all state updates on the rising edge of CLK_PX.
- Reset values:
  - counters h = v = 0; PX_ADDR = OVL_ADDR = 0.
  - DE = 0, HDMI_PX = 0, FRAME_START = 0.
  - HSYNC = VSYNC = inactive level (~SYNC_POL).
  - Pipeline cleared.
- Reset asserted mid-frame: takes effect next edge; raster restarts at h = 0, v = 0 (first active pixel).
- Counter stage:
  - h counts 0..H_TOTAL-1 and wraps, where H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP.
  - v increments on h wrap; v counts 0..V_TOTAL-1 and wraps.
  - Region order per line: active [0, H_ACTIVE), then front porch, then sync, then back porch. Vertical order is the same.
  - Raw signals:
    - act = (h < H_ACTIVE) && (v < V_ACTIVE)
    - hs_raw = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
    - vs_raw likewise on v
- Frame start (h = 0, v = 0):
  - Latch OVL_EN, OVL_X, OVL_Y, KEY into shadow registers.
  - Mid-frame input changes have no effect until the next frame start.
- Overlay window: in_ovl = shadow_en && act && h - OVL_X in [0, OVL_W) && v - OVL_Y in [0, OVL_H).
  - Window portions beyond H_ACTIVE / V_ACTIVE are clipped, i.e. not displayed.
- Address generation, combinational from counter stage, registered outputs:
  - PX_ADDR = v*H_ACTIVE + h while act. Implemented incrementally: +1 per active pixel, reset to 0 at frame start. Held otherwise.
  - OVL_ADDR = (v-OVL_Y)*OVL_W + (h-OVL_X) while in_ovl. Incremental: starts at (first visible row offset)*OVL_W + first visible column offset, accounting for clipping. Held otherwise.
  - Address register adds 1 cycle.
- Output alignment:
  - act, in_ovl, hs_raw, vs_raw and the frame-start flag are delayed by a shift pipeline of depth MEM_LAT+1.
  - Colour select is registered, giving total pixel latency MEM_LAT+2 from counter to HDMI_PX; sync/DE use the same depth.
  - DE, HSYNC, VSYNC and HDMI_PX therefore change on the same edge.
- Colour select (registered):
  - !act_d: HDMI_PX = 0
  - in_ovl_d && OVL_PX != key: OVL_PX
  - else INV ? ~PX : PX. INV is sampled at the aligned stage, not shadowed.
- Arithmetic: addresses wrap modulo 2^PX_AW / 2^OVL_AW. Width-overflow is the integrator's responsibility; the default parameters fit.

Optional Feature:
- Macro: HDMI_TEST_PATTERN_EN.
- When defined:
  - Adds input TPG (1 bit), sampled at frame start.
  - If latched high, background PX is replaced with 8 vertical colour bars, each H_ACTIVE/8 wide. Order: white, yellow, cyan, green, magenta, red, blue, black.
  - Overlay and INV still apply. PX_ADDR still advances.
- When undefined: no TPG port; behaviour exactly as above.

Test Plan:
1. Timing at defaults, OVL_EN = 0, PX = 24'h101010, run two frames:
   - HSYNC low for 96 cycles per 800-cycle line.
   - VSYNC low for 2 lines per 525-line frame.
   - DE high 640x480 per frame.
   - FRAME_START exactly once per 420000 cycles.
2. Alignment with MEM_LAT = 3, memory model returning pixel value = address:
   - First DE cycle shows HDMI_PX = 0.
   - Pixel (639, 479) shows 307199.
   - DE rises exactly when the first valid pixel appears.
3. Overlay and key with OVL_X = 10, OVL_Y = 20, KEY = 0, OVL_PX = address except address 5 returns 0:
   - Pixel (10, 20) = overlay 0.
   - Pixel (15, 20) shows background (keyed).
   - Pixel (109, 59) = overlay 3999.
   - Pixel (110, 59) shows background.
4. Clipping with OVL_X = 600, OVL_Y = 470:
   - Only a 40x10 region is displayed.
   - Row 471 begins at OVL_ADDR = 100.
   - No overlay pixels wrap to the next line or frame.
5. Shadowing: change OVL_X from 10 to 50 mid-frame at line 100:
   - Current frame keeps the overlay at column 10.
   - Next frame shows it at column 50.
6. Reset: assert RST for 1 cycle at line 200:
   - Next cycle DE = 0, addresses = 0, syncs inactive.
   - After release, timing restarts from h = 0, v = 0 and is correct thereafter.
   - INV = 1 yields ~PX outside the overlay.
